// File: rtl/rename_reg_file.sv
// rtl/rename_reg_file.sv - architectural register file with per-register rename tags
//
// Purpose: holds committed integer register values plus, per register, a dirty
// bit and the ROB tag of the in-flight producer. Decoder read ports resolve each
// operand to either a value or a dependency tag, forwarding same-cycle commits
// and ROB results that are already available.
//
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    state only advances while high
//   flush_in                  mispredict: drop every rename, keep committed values
//   commit_valid/id/data/tag  ROB retires a register write
//   issue_valid/id/tag        ROB allocates an entry with a destination register
//   rd_id                     NRD packed read register IDs
//   rd_val/rd_busy/rd_tag     per-port operand value or producing ROB entry
//   rob_q_tag                 per-port ROB readiness query (tag of the register)
//   rob_q_rdy/rob_q_val       ROB answer to the query
//   busy_cnt                  registered count of dirty registers

module rename_reg_file #(
    parameter int  XLEN    = 32,
    parameter int  NREG    = 32,
    parameter int  ROB_BIT = 4,
    parameter int  NRD     = 2,
    localparam int RW      = $clog2(NREG)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   commit_valid,
    input  logic [RW-1:0]          commit_id,
    input  logic [XLEN-1:0]        commit_data,
    input  logic [ROB_BIT-1:0]     commit_tag,
    input  logic                   issue_valid,
    input  logic [RW-1:0]          issue_id,
    input  logic [ROB_BIT-1:0]     issue_tag,
    input  logic [NRD*RW-1:0]      rd_id,
    output logic [NRD*XLEN-1:0]    rd_val,
    output logic [NRD-1:0]         rd_busy,
    output logic [NRD*ROB_BIT-1:0] rd_tag,
    output logic [NRD*ROB_BIT-1:0] rob_q_tag,
    input  logic [NRD-1:0]         rob_q_rdy,
    input  logic [NRD*XLEN-1:0]    rob_q_val,
    output logic [RW:0]            busy_cnt
);

    logic [XLEN-1:0]    regs_q  [NREG];
    logic [ROB_BIT-1:0] tag_q   [NREG];
    logic [NREG-1:0]    dirty_q;

    logic [ROB_BIT-1:0] tag_d   [NREG];
    logic [NREG-1:0]    dirty_d;
    logic [RW:0]        cnt_d;

    // Read ports: x0 first, then a same-cycle rename (the decoder reads after
    // its own issue slot), then commit/ROB forwarding, then the stored state.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RW-1:0]      id;
        logic [XLEN-1:0]    val;
        logic               busy;
        logic [ROB_BIT-1:0] tg;

        assign id = rd_id[k*RW +: RW];

        always_comb begin
            val  = '0;
            busy = 1'b0;
            tg   = '0;
            if (id == '0) begin
                val = '0;
            end else if (issue_valid && issue_id == id) begin
                busy = 1'b1;
                tg   = issue_tag;
            end else if (dirty_q[id] && commit_valid && commit_tag == tag_q[id]) begin
                val = commit_data;
            end else if (dirty_q[id] && rob_q_rdy[k]) begin
                val = rob_q_val[k*XLEN +: XLEN];
            end else if (dirty_q[id]) begin
                busy = 1'b1;
                tg   = tag_q[id];
            end else begin
                val = regs_q[id];
            end
        end

        assign rd_val[k*XLEN +: XLEN]       = val;
        assign rd_busy[k]                   = busy;
        assign rd_tag[k*ROB_BIT +: ROB_BIT] = tg;
        assign rob_q_tag[k*ROB_BIT +: ROB_BIT] = tag_q[id];
    end

    // Rename-state update. A commit only releases the register when it retires
    // the latest producer; an issue to the same register in the same cycle
    // installs the newer producer and wins.
    always_comb begin
        dirty_d = dirty_q;
        tag_d   = tag_q;
        if (flush_in) begin
            dirty_d = '0;
            for (int i = 0; i < NREG; i++) begin
                tag_d[i] = '0;
            end
        end else begin
            if (commit_valid && commit_id != '0 && dirty_q[commit_id] &&
                tag_q[commit_id] == commit_tag &&
                !(issue_valid && issue_id == commit_id)) begin
                dirty_d[commit_id] = 1'b0;
                tag_d[commit_id]   = '0;
            end
            if (issue_valid && issue_id != '0) begin
                dirty_d[issue_id] = 1'b1;
                tag_d[issue_id]   = issue_tag;
            end
        end

        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (RW+1)'(dirty_d[i]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            dirty_q  <= '0;
            busy_cnt <= '0;
        end else if (rdy_in) begin
            // Committed values are architectural, so they land even on flush.
            if (commit_valid && commit_id != '0) begin
                regs_q[commit_id] <= commit_data;
            end
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            busy_cnt <= cnt_d;
        end
    end

    // The ROB can never retire and allocate the same entry in one cycle.
    assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(commit_valid && issue_valid && commit_tag == issue_tag))
        else $fatal(1, "rename_reg_file: commit_tag equals issue_tag in one cycle");

endmodule

// File: tb/tb_rename_reg_file.sv
// tb/tb_rename_reg_file.sv - directed self-checking bench for rename_reg_file

module tb_rename_reg_file;

    localparam int XLEN = 32, NREG = 32, ROB_BIT = 4, NRD = 2, RW = 5;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in;
    logic                   rdy_in;
    logic                   flush_in;
    logic                   commit_valid;
    logic [RW-1:0]          commit_id;
    logic [XLEN-1:0]        commit_data;
    logic [ROB_BIT-1:0]     commit_tag;
    logic                   issue_valid;
    logic [RW-1:0]          issue_id;
    logic [ROB_BIT-1:0]     issue_tag;
    logic [NRD*RW-1:0]      rd_id;
    logic [NRD*XLEN-1:0]    rd_val;
    logic [NRD-1:0]         rd_busy;
    logic [NRD*ROB_BIT-1:0] rd_tag;
    logic [NRD*ROB_BIT-1:0] rob_q_tag;
    logic [NRD-1:0]         rob_q_rdy;
    logic [NRD*XLEN-1:0]    rob_q_val;
    logic [RW:0]            busy_cnt;

    int n_chk = 0;
    int n_fail = 0;

    rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .ROB_BIT(ROB_BIT), .NRD(NRD)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_data(commit_data),
        .commit_tag(commit_tag), .issue_valid(issue_valid), .issue_id(issue_id),
        .issue_tag(issue_tag), .rd_id(rd_id), .rd_val(rd_val), .rd_busy(rd_busy),
        .rd_tag(rd_tag), .rob_q_tag(rob_q_tag), .rob_q_rdy(rob_q_rdy),
        .rob_q_val(rob_q_val), .busy_cnt(busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [XLEN-1:0] val(input int k);
        return rd_val[k*XLEN +: XLEN];
    endfunction

    function automatic logic [ROB_BIT-1:0] tagp(input int k);
        return rd_tag[k*ROB_BIT +: ROB_BIT];
    endfunction

    function automatic logic [ROB_BIT-1:0] qtag(input int k);
        return rob_q_tag[k*ROB_BIT +: ROB_BIT];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        flush_in     = 1'b0;
        commit_valid = 1'b0;
        commit_id    = '0;
        commit_data  = '0;
        commit_tag   = '0;
        issue_valid  = 1'b0;
        issue_id     = '0;
        issue_tag    = '0;
        rob_q_rdy    = '0;
        rob_q_val    = '0;
    endtask

    task automatic set_rd(input logic [RW-1:0] a, input logic [RW-1:0] b);
        rd_id = {b, a};
        #1;
    endtask

    task automatic do_issue(input logic [RW-1:0] id, input logic [ROB_BIT-1:0] t);
        issue_valid = 1'b1;
        issue_id    = id;
        issue_tag   = t;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        rdy_in   = 1'b1;
        rd_id    = '0;
        idle();
        step();
        step();
        rst_n_in = 1'b1;
        step();
        set_rd(5'd5, 5'd0);
        n_chk++; if (rd_val !== '0 || rd_busy !== '0 || rd_tag !== '0) begin n_fail++; $display("FAIL reset_read_a: val=%h busy=%b tag=%h exp 0", rd_val, rd_busy, rd_tag); end
        set_rd(5'd0, 5'd5);
        n_chk++; if (rd_val !== '0 || rd_busy !== '0 || rd_tag !== '0) begin n_fail++; $display("FAIL reset_read_b: val=%h busy=%b tag=%h exp 0", rd_val, rd_busy, rd_tag); end
        n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d exp 0", busy_cnt); end
        commit_valid = 1'b1;
        commit_id    = 5'd0;
        commit_data  = 32'hDEAD;
        step();
        idle();
        set_rd(5'd0, 5'd0);
        n_chk++; if (val(0) !== 32'h0 || val(1) !== 32'h0 || rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_write_ignored: val=%h busy=%b exp 0", rd_val, rd_busy); end
    endtask

    task automatic test_rename();
        set_rd(5'd3, 5'd3);
        issue_valid = 1'b1;
        issue_id    = 5'd3;
        issue_tag   = 4'd2;
        #1;
        n_chk++; if (rd_busy[0] !== 1'b1 || tagp(0) !== 4'd2 || val(0) !== 32'h0) begin n_fail++; $display("FAIL same_cycle_rename: busy=%b tag=%h val=%h exp 1/2/0", rd_busy[0], tagp(0), val(0)); end
        step();
        idle();
        #1;
        n_chk++; if (qtag(0) !== 4'd2 || rd_busy[0] !== 1'b1 || tagp(0) !== 4'd2) begin n_fail++; $display("FAIL dirty_wait: qtag=%h busy=%b tag=%h exp 2/1/2", qtag(0), rd_busy[0], tagp(0)); end
        rob_q_rdy = 2'b01;
        rob_q_val = {32'h0, 32'h55};
        #1;
        n_chk++; if (rd_busy[0] !== 1'b0 || val(0) !== 32'h55 || tagp(0) !== 4'd0) begin n_fail++; $display("FAIL rob_forward: busy=%b val=%h tag=%h exp 0/55/0", rd_busy[0], val(0), tagp(0)); end
        n_chk++; if (rd_busy[1] !== 1'b1 || tagp(1) !== 4'd2) begin n_fail++; $display("FAIL rob_forward_port1: busy=%b tag=%h exp 1/2", rd_busy[1], tagp(1)); end
        n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL rename_busy_cnt: got %0d exp 1", busy_cnt); end
        idle();
    endtask

    task automatic test_commit_forward();
        set_rd(5'd3, 5'd0);
        commit_valid = 1'b1;
        commit_id    = 5'd3;
        commit_data  = 32'h1234;
        commit_tag   = 4'd2;
        #1;
        n_chk++; if (val(0) !== 32'h1234 || rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL commit_forward: val=%h busy=%b exp 1234/0", val(0), rd_busy[0]); end
        step();
        idle();
        #1;
        n_chk++; if (val(0) !== 32'h1234 || rd_busy[0] !== 1'b0 || qtag(0) !== 4'd0) begin n_fail++; $display("FAIL commit_stored: val=%h busy=%b qtag=%h exp 1234/0/0", val(0), rd_busy[0], qtag(0)); end
        n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL commit_busy_cnt: got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_stale_commit();
        do_issue(5'd4, 4'd1);
        do_issue(5'd4, 4'd5);
        commit_valid = 1'b1;
        commit_id    = 5'd4;
        commit_data  = 32'd7;
        commit_tag   = 4'd1;
        step();
        idle();
        set_rd(5'd4, 5'd4);
        n_chk++; if (rd_busy[0] !== 1'b1 || tagp(0) !== 4'd5) begin n_fail++; $display("FAIL stale_commit_keeps_rename: busy=%b tag=%h exp 1/5", rd_busy[0], tagp(0)); end
        n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL stale_busy_cnt: got %0d exp 1", busy_cnt); end
        commit_valid = 1'b1;
        commit_id    = 5'd4;
        commit_data  = 32'd9;
        commit_tag   = 4'd5;
        #1;
        n_chk++; if (val(1) !== 32'd9 || rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL latest_commit_forward: val=%h busy=%b exp 9/0", val(1), rd_busy[1]); end
        step();
        idle();
        #1;
        n_chk++; if (val(0) !== 32'd9 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin n_fail++; $display("FAIL latest_commit_stored: val=%h busy=%b cnt=%0d exp 9/0/0", val(0), rd_busy[0], busy_cnt); end
    endtask

    task automatic test_commit_issue_same();
        commit_valid = 1'b1;
        commit_id    = 5'd6;
        commit_data  = 32'hAA;
        commit_tag   = 4'd3;
        issue_valid  = 1'b1;
        issue_id     = 5'd6;
        issue_tag    = 4'd4;
        step();
        idle();
        set_rd(5'd6, 5'd0);
        n_chk++; if (rd_busy[0] !== 1'b1 || tagp(0) !== 4'd4 || qtag(0) !== 4'd4) begin n_fail++; $display("FAIL issue_beats_commit: busy=%b tag=%h qtag=%h exp 1/4/4", rd_busy[0], tagp(0), qtag(0)); end
        n_chk++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL issue_commit_busy_cnt: got %0d exp 1", busy_cnt); end
        flush_in = 1'b1;
        step();
        idle();
        #1;
        n_chk++; if (val(0) !== 32'hAA || rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL commit_data_landed: val=%h busy=%b exp aa/0", val(0), rd_busy[0]); end
    endtask

    task automatic test_flush();
        do_issue(5'd1, 4'd1);
        do_issue(5'd2, 4'd2);
        do_issue(5'd7, 4'd6);
        n_chk++; if (busy_cnt !== 6'd3) begin n_fail++; $display("FAIL pre_flush_busy_cnt: got %0d exp 3", busy_cnt); end
        flush_in     = 1'b1;
        commit_valid = 1'b1;
        commit_id    = 5'd1;
        commit_data  = 32'h11;
        commit_tag   = 4'd1;
        issue_valid  = 1'b1;
        issue_id     = 5'd8;
        issue_tag    = 4'd9;
        step();
        idle();
        n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL flush_busy_cnt: got %0d exp 0", busy_cnt); end
        set_rd(5'd1, 5'd8);
        n_chk++; if (val(0) !== 32'h11 || rd_busy !== 2'b00 || val(1) !== 32'h0) begin n_fail++; $display("FAIL flush_reads: v0=%h v1=%h busy=%b exp 11/0/00", val(0), val(1), rd_busy); end
        set_rd(5'd2, 5'd7);
        n_chk++; if (rd_busy !== 2'b00 || rd_tag !== '0 || rob_q_tag !== '0) begin n_fail++; $display("FAIL flush_clean: busy=%b tag=%h qtag=%h exp 0", rd_busy, rd_tag, rob_q_tag); end
    endtask

    task automatic test_rdy_hold();
        rdy_in       = 1'b0;
        issue_valid  = 1'b1;
        issue_id     = 5'd9;
        issue_tag    = 4'd3;
        commit_valid = 1'b1;
        commit_id    = 5'd10;
        commit_data  = 32'h77;
        commit_tag   = 4'd0;
        step();
        idle();
        rdy_in = 1'b1;
        set_rd(5'd9, 5'd10);
        n_chk++; if (rd_busy !== 2'b00 || val(1) !== 32'h0) begin n_fail++; $display("FAIL rdy_low_hold: busy=%b v1=%h exp 00/0", rd_busy, val(1)); end
        n_chk++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rdy_low_busy_cnt: got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_async_reset();
        do_issue(5'd5, 4'd7);
        commit_valid = 1'b1;
        commit_id    = 5'd12;
        commit_data  = 32'h99;
        commit_tag   = 4'd0;
        step();
        idle();
        set_rd(5'd5, 5'd12);
        n_chk++; if (rd_busy[0] !== 1'b1 || val(1) !== 32'h99 || busy_cnt !== 6'd1) begin n_fail++; $display("FAIL pre_reset_state: busy0=%b v1=%h cnt=%0d exp 1/99/1", rd_busy[0], val(1), busy_cnt); end
        // Now at edge+2; reset drops at edge+3 and is sampled at edge+4.
        #1;
        rst_n_in = 1'b0;
        #1;
        n_chk++; if (rd_busy !== 2'b00 || val(1) !== 32'h0 || busy_cnt !== 6'd0 || rob_q_tag !== '0) begin n_fail++; $display("FAIL async_reset: busy=%b v1=%h cnt=%0d qtag=%h exp 0", rd_busy, val(1), busy_cnt, rob_q_tag); end
        step();
        rst_n_in = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_rename();
        test_commit_forward();
        test_stale_commit();
        test_commit_issue_same();
        test_flush();
        test_rdy_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural integer register file with per-register rename tags for the Tomasulo core.
- Sits between decoder (operand lookup), ROB (issue/commit/flush, operand readiness query) and RS/LSB (operand values or dependency tags).
- Generalises the previous two-port file to NRD read ports, parametrised data/tag widths, same-cycle commit forwarding, x0 hard-wiring on every path, and a registered busy-register count.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count (power of two); ID width RW = $clog2(NREG)
ROB_BIT, 4, ROB tag width
NRD, 2, number of decoder read ports

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  pause: no state change while low
flush_in  in  1  ROB mispredict clear-up
commit_valid  in  1  ROB commits a register write
commit_id  in  RW  destination register
commit_data  in  XLEN  committed value
commit_tag  in  ROB_BIT  ROB entry being committed
issue_valid  in  1  ROB allocates an entry with a destination
issue_id  in  RW  destination register
issue_tag  in  ROB_BIT  allocated ROB entry
rd_id  in  NRD*RW  read register IDs, port k at [k*RW +: RW]
rd_val  out  NRD*XLEN  operand value (valid when rd_busy=0)
rd_busy  out  NRD  operand waits on a ROB entry
rd_tag  out  NRD*ROB_BIT  producing ROB entry when busy, else 0
rob_q_tag  out  NRD*ROB_BIT  ROB readiness query, one per port
rob_q_rdy  in  NRD  queried entry has its result
rob_q_val  in  NRD*XLEN  queried entry's result
busy_cnt  out  RW+1  registered number of dirty registers

Behaviour:
- State: regs[NREG], dirty[NREG], tag[NREG], busy_cnt. rst_n_in low (async): all cleared to 0. All outputs combinational from state/inputs except busy_cnt; after reset every read returns val 0, busy 0, tag 0.
- Read port k (combinational, zero latency), priority order:
  1. rd_id==0 -> val 0, busy 0, tag 0.
  2. issue_valid && issue_id==rd_id (issue_id!=0) -> busy 1, tag=issue_tag, val 0 (same-cycle rename wins; decoder reads after its own issue slot).
  3. dirty[id] && commit_valid && commit_tag==tag[id] -> val=commit_data, busy 0, tag 0.
  4. dirty[id] && rob_q_rdy[k] -> val=rob_q_val[k], busy 0, tag 0.
  5. dirty[id] -> busy 1, tag=tag[id], val 0.
  6. else val=regs[id], busy 0, tag 0.
- rob_q_tag[k] = tag[rd_id[k]] always.
- Clock edge, rdy_in low: nothing changes.
- Clock edge, rdy_in high:
  - commit_valid && commit_id!=0: regs[commit_id] <= commit_data, also during flush (committed = architectural). commit_id==0: ignored.
  - Commit clears dirty[commit_id] and tag only if tag[commit_id]==commit_tag and no same-cycle issue to commit_id.
  - issue_valid && issue_id!=0 && !flush_in: dirty/tag[issue_id] <= 1/issue_tag. Issue beats commit on the same register.
  - flush_in: all dirty and tags <= 0; issue ignored.
  - busy_cnt <= popcount of next-state dirty[] (0 after flush). Range 0..NREG-1 (x0 never dirty).
- Unmatched commit (reg not dirty, or tag mismatch): data still written, rename state untouched. Not an error.
- Simulation-only assertion: commit_tag==issue_tag with both valid is a fatal error (ROB cannot retire and allocate one entry in the same cycle).

Test Plan:
- Reset then read x5 and x0 on both ports -> val 0, busy 0, busy_cnt 0; write x0 via commit (data 0xDEAD) -> x0 still reads 0.
- Issue x3 tag 2; same cycle read x3 -> busy 1, tag 2; next cycle rob_q_tag=2, rob_q_rdy=0 -> busy 1; raise rob_q_rdy, rob_q_val=0x55 -> busy 0, val 0x55; busy_cnt=1.
- Commit x3 tag 2 data 0x1234 while reading x3 -> val 0x1234 same cycle; next cycle dirty clear, reads regs=0x1234, busy_cnt=0.
- Issue x4 tag 1, then issue x4 tag 5, then commit x4 tag 1 data 7 -> regs[x4]=7 but read stays busy tag 5; commit tag 5 data 9 -> val 9, busy 0.
- Same cycle: commit x6 tag 3 data 0xAA, issue x6 tag 4 -> x6 dirty with tag 4, regs[x6]=0xAA.
- Dirty x1,x2,x7 (busy_cnt=3); flush with commit x1 data 0x11 and issue x8 -> all clean, x1 reads 0x11, x8 not dirty, busy_cnt 0. Hold rdy_in low during an issue -> no change. Assert rst_n_in mid-sequence -> all state 0 immediately, without waiting for a clock edge.
